smvm_row_collector: RTL
=======================

# smvm_row_collector

Downstream output stage of the sparse matrix-vector multiplier. Receives per-row partial sums from the adder tree / AAC path, tagged with a row index. Accumulates multiple partials for the same row and, on end-of-matrix, streams one saturated 24-bit result per row in row order 0..rows-1. Rows that received no partials stream as zero.

## Interface
- MAX_ROWS, 128: result buffer depth and maximum matrix rows.
- ACC_W, 28: partial-sum and accumulator width, signed.
- OUT_W, 24: output width, signed.

- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse that opens a new matrix; sampled only in IDLE.
- rows_in  input  8  row count, sampled with start.
- res_valid  input  1  partial-sum strobe; sampled only in COLLECT.
- res_row  input  8  row index of the partial.
- res_data  input  ACC_W  signed partial sum.
- done  input  1  one-cycle pulse marking the last partial of the matrix; sampled only in COLLECT.
- busy  output  1  high in COLLECT and DRAIN.
- out_valid  output  1  registered result strobe.
- data_out  output  OUT_W  registered signed row result.

## Operation
- States:
  - IDLE: start with rows_in != 0 → COLLECT. Latch rows = min(rows_in, MAX_ROWS). start with rows_in == 0 stays in IDLE.
  - COLLECT: res_valid adds res_data into acc[res_row]. done → DRAIN.
  - DRAIN: emits rows results one per cycle, then → IDLE.
- Accumulation: acc is ACC_W-bit two's-complement and wraps on overflow. A row may receive any number of partials, in any order, on any cycles.
- res_valid with res_row >= rows: ignored; no entry is modified.
- res_valid and done in the same cycle: the partial is accumulated first, then the state moves to DRAIN. It is included in the output.
- start outside IDLE: ignored. res_valid or done outside COLLECT: ignored.
- Drain:
  - Read pointer runs 0..rows-1.
  - data_out = acc[ptr] saturated to OUT_W: values > 2^23-1 → 0x7FFFFF; values < -2^23 → 0x800000; otherwise the low 24 bits.
  - Each entry is cleared to 0 as it is read, so the buffer is all-zero on return to IDLE.
- busy = (state != IDLE).

## Timing
- Reset (async assert, any state): state=IDLE, rows=0, pointer=0, all acc=0, out_valid=0, data_out=0, busy=0. Mid-drain reset aborts the drain immediately; no further out_valid.
- start sampled at edge E: busy high from E. A partial is accepted from edge E+1.
- done sampled at edge D: row r drives out_valid=1 with its data_out in the cycle after edge D+1+r, for r = 0..rows-1.
  - Exactly rows consecutive valid cycles, no gaps.
  - out_valid=0 and data_out=0 in every other cycle.
- Returns to IDLE at the edge that registers the last row. busy drops with that edge. A start in the same cycle as the last out_valid is accepted.
- Partial acceptance: one per cycle, zero bubble. A partial to row r in the same cycle as another to r accumulates both in order of arrival; only one port exists, so this never collides.
- No backpressure: the consumer must accept out_valid every cycle.

## Test plan
- Basic:
  - Stimulus: start rows_in=4; partials (row0,+5), (row2,-3), (row0,+7); done.
  - Response: out_valid for 4 cycles starting 2 cycles after done, data_out = 12, 0, -3, 0.
- Saturation:
  - Stimulus: rows_in=2; row0 partials 0x3FFFFF and 0x600000; row1 partial -0x900000; done.
  - Response: data_out = 0x7FFFFF, then 0x800000.
- Boundary:
  - Stimulus: rows_in=200; partial to row127=+1; partial to row128=+9; done.
  - Response: 128 valid cycles; row127=1; all others 0; the row128 partial is dropped.
- Simultaneous:
  - Stimulus: rows_in=1; res_valid (row0,+10) in the same cycle as done.
  - Response: single output 10. A start pulsed in the out_valid cycle is accepted; a second matrix with no partials then outputs 0, proving the buffer was cleared.
- Reset mid-drain:
  - Stimulus: rows_in=8, row r = r+1; assert rst_n=0 after the 3rd out_valid.
  - Response: outputs 1, 2, 3 then immediate out_valid=0 and busy=0. A new matrix with rows_in=8 and no partials outputs eight zeros.
- Ignored controls:
  - Stimulus: res_valid (row0,+4) and done pulsed in IDLE, then start rows_in=0.
  - Response: busy stays 0 and no out_valid. A following start rows_in=1 with done outputs 0.

Source files
------------

// File: rtl/smvm_row_collector.sv
// smvm_row_collector: gathers per-row partial sums of a sparse matrix-vector
// product, then streams one saturated result per row in row order, clearing
// each entry as it is read so the buffer is empty for the next matrix.
module smvm_row_collector #(
  parameter int MAX_ROWS = 128,
  parameter int ACC_W    = 28,
  parameter int OUT_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       rows_in,
  input  logic             res_valid,
  input  logic [7:0]       res_row,
  input  logic [ACC_W-1:0] res_data,
  input  logic             done,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] data_out
);

  localparam int AW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam logic [7:0] MAX_ROWS_B = 8'(MAX_ROWS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       rows;
  logic [7:0]       ptr;
  logic [ACC_W-1:0] acc [MAX_ROWS];

  logic             load;
  logic             accept;
  logic             emit;
  logic             last;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic signed [ACC_W-1:0] rd_val;
  logic [OUT_W-1:0] sat_val;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: open on a non-empty start, drain on done, idle after last row.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && rows_in != 8'd0) state_nxt = COLLECT;
      COLLECT: if (done)                     state_nxt = DRAIN;
      DRAIN:   if (last)                     state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Control strobes derived from the current state and inputs.
  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && start && (rows_in != 8'd0);
    accept = (state == COLLECT) && res_valid && (res_row < rows);
    emit   = (state == DRAIN);
    last   = (ptr == rows - 8'd1);
    wr_idx = res_row[AW-1:0];
    rd_idx = ptr[AW-1:0];
  end

  // Saturate the entry under the read pointer to the output width.
  always_comb begin
    rd_val = acc[rd_idx];
    if (rd_val > SAT_HI)      sat_val = SAT_HI[OUT_W-1:0];
    else if (rd_val < SAT_LO) sat_val = SAT_LO[OUT_W-1:0];
    else                      sat_val = rd_val[OUT_W-1:0];
  end

  // Row count latch and drain read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows <= '0;
      ptr  <= '0;
    end else if (load) begin
      rows <= (rows_in > MAX_ROWS_B) ? MAX_ROWS_B : rows_in;
      ptr  <= '0;
    end else if (emit) begin
      ptr  <= last ? '0 : ptr + 8'd1;
    end
  end

  // Accumulator buffer: wrap-around add while collecting, clear-on-read while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_ROWS; i++) acc[i] <= '0;
    end else if (accept) begin
      acc[wr_idx] <= acc[wr_idx] + res_data;
    end else if (emit) begin
      acc[rd_idx] <= '0;
    end
  end

  // Registered result stream; data is forced to zero outside valid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= emit;
      data_out  <= emit ? sat_val : '0;
    end
  end

endmodule
